mtsp_mo_phase_scheduler: RTL
============================

Name: mtsp_mo_phase_scheduler

Overview:
- Sequences one unit-instruction bundle (phase #0 + phase #1 micro-operation pair) onto the single shared MO datapath.
- Issues phase #0, then phase #1, each at most one per cycle.
- Holds issue while a GPR RAW/WAW hazard is pending against in-flight writes; tracks in-flight writes through a scoreboard plus a PIPE_LAT-deep writeback shift line.
- Sits between instruction fetch/decode and the MO dispatch/ALU stage.

Parameters:
- GPR_AW, 7, GPR address width; scoreboard holds 2^GPR_AW bits.
- PIPE_LAT, 4, cycles from issue to GPR writeback (>=1).

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- FLUSH  in  1  drop held bundle; in-flight writebacks unaffected
- BUNDLE_VALID  in  1  bundle offered
- BUNDLE_READY  out  1  bundle accepted when VALID&READY
- P0_EN, P1_EN  in  1  phase has ALU work (0 = phase skipped)
- P0_WADDR, P1_WADDR  in  GPR_AW  phase dest GPR (P1 already relative-adjusted)
- P0_RADDR0, P0_RADDR1, P1_RADDR0, P1_RADDR1  in  GPR_AW  phase source GPRs
- ISSUE_VALID  out  1  MO datapath issue strobe
- ISSUE_PHASE  out  1  0 = phase #0, 1 = phase #1
- ISSUE_WADDR  out  GPR_AW  dest of issued phase
- WB_VALID  out  1  writeback strobe (PIPE_LAT after issue)
- WB_WADDR  out  GPR_AW  writeback dest
- BUSY  out  1  state != IDLE or any scoreboard bit set
- STALL_COUNT  out  16  hazard-stall cycles (optional feature)

Behaviour:
- One clock: CLK. Reset is synchronous and active-high: RST.
- Reset: state IDLE, scoreboard 0, shift line 0. All outputs 0, except BUNDLE_READY=1 from the first cycle after reset.
- Reset mid-operation discards the held bundle and all in-flight writebacks; no WB_VALID follows.
- FSM states:
  - IDLE: READY=1. On accept, latch all P* inputs.
    - P0_EN=1 → PH0.
    - else P1_EN=1 → PH1.
    - else stay IDLE (empty bundle consumed, nothing issued).
  - PH0: issue phase #0 if hz0=0.
    - Then PH1 if latched P1_EN, else IDLE.
    - hz0=1 → stay; ISSUE_VALID=0.
  - PH1: issue phase #1 if hz1=0.
    - On issue, READY=1 in the same cycle. A new bundle accepted that cycle transitions directly as in IDLE (back-to-back, no bubble).
    - Otherwise → IDLE.
- Hazard: hzN = SB[RADDR0] | SB[RADDR1] | SB[WADDR] for the latched phase.
  - SB is the registered scoreboard; no same-cycle bypass.
  - A clear landing this cycle still stalls issue for 1 cycle.
- Issue is combinational from state and registered SB: ISSUE_VALID/PHASE/WADDR are valid in the same cycle.
  - Earliest phase #0 issue is the cycle after accept; phase #1 follows one cycle later.
  - If phase #1 reads the phase #0 dest, phase #1 issues PIPE_LAT+1 cycles after phase #0.
- Scoreboard update on issue: SB[ISSUE_WADDR] set; {1, ISSUE_WADDR} enters the shift line.
- Writeback: after PIPE_LAT cycles, WB_VALID=1 with WB_WADDR, registered. SB[WB_WADDR] clears in the same edge as WB_VALID asserts.
- Simultaneous set and clear: WAW stall guarantees different addresses. If equal (only possible on a model error), set wins.
- FLUSH:
  - Forces IDLE next cycle, drops latched phases, READY=1.
  - FLUSH in a cycle where an issue would fire suppresses that issue (ISSUE_VALID=0).
  - FLUSH with BUNDLE_VALID: bundle is not accepted (READY=0 that cycle).
  - Scoreboard and shift line continue draining.
- ISSUE_WADDR holds its last value when ISSUE_VALID=0; WB_WADDR likewise when WB_VALID=0.

Optional Feature:
- Macro MTSP_SCHED_PERF_EN.
- Defined: STALL_COUNT counts cycles in PH0/PH1 with hazard=1 and FLUSH=0.
  - Saturates at 16'hFFFF.
  - Cleared by RST only.
- Undefined: STALL_COUNT tied to 16'h0; no counter logic.

Test Plan:
- Reset then bundle (P0_EN=1 W=5 R=1,2; P1_EN=1 W=6 R=3,4) accepted at T → ISSUE phase0 W=5 at T+1, phase1 W=6 at T+2; WB W=5 at T+5, W=6 at T+6 (PIPE_LAT=4).
- Phase1 RADDR0=5 = phase0 dest → phase0 at T+1, phase1 at T+6 (WB clears at T+5, no bypass); STALL_COUNT=4 with MTSP_SCHED_PERF_EN, 0 without.
- P0_EN=0, P1_EN=1 W=9 → single issue, ISSUE_PHASE=1 at T+1; bundle with both EN=0 → no issue, READY stays 1.
- Three independent bundles offered continuously → ISSUE_VALID high on 6 consecutive cycles, READY high on each PH1 issue cycle.
- Phase0 stalled on SB[7] with FLUSH pulsed → no issue, IDLE next cycle, pending WB W=7 still appears; next bundle accepted.
- RST asserted 2 cycles after issue → no WB_VALID afterwards, BUSY=0, all outputs 0.

Source files
------------

// File: rtl/mtsp_mo_phase_scheduler_if.sv
// ---------------------------------------------------------------------------
// mtsp_mo_phase_scheduler_if
//   Bundle-in / issue-out / writeback-out signal group of the MO phase
//   scheduler. CLK and RST are not part of this group; they stay plain ports
//   on the scheduler itself.
//
//   Handshake: a bundle transfers on a cycle where BUNDLE_VALID and
//   BUNDLE_READY are both high. The P* fields must be stable while
//   BUNDLE_VALID is high. READY may depend combinationally on FLUSH and on
//   the scheduler's registered state, but never on BUNDLE_VALID.
//   ISSUE_VALID and WB_VALID are single-cycle strobes with no back-pressure.
//
//   Modports:
//     master - fetch/decode side: drives FLUSH and the bundle, observes
//              everything the scheduler produces.
//     slave  - the scheduler.
//
//   Parameter GPR_AW : GPR address width.
// ---------------------------------------------------------------------------
interface mtsp_mo_phase_scheduler_if #(
    parameter int GPR_AW = 7
);
    logic              FLUSH;
    logic              BUNDLE_VALID;
    logic              BUNDLE_READY;
    logic              P0_EN;
    logic              P1_EN;
    logic [GPR_AW-1:0] P0_WADDR;
    logic [GPR_AW-1:0] P1_WADDR;
    logic [GPR_AW-1:0] P0_RADDR0;
    logic [GPR_AW-1:0] P0_RADDR1;
    logic [GPR_AW-1:0] P1_RADDR0;
    logic [GPR_AW-1:0] P1_RADDR1;
    logic              ISSUE_VALID;
    logic              ISSUE_PHASE;
    logic [GPR_AW-1:0] ISSUE_WADDR;
    logic              WB_VALID;
    logic [GPR_AW-1:0] WB_WADDR;
    logic              BUSY;
    logic [15:0]       STALL_COUNT;
    logic [1:0]        state_dbg;    // scheduler FSM state, for observation only

    modport master (
        output FLUSH, BUNDLE_VALID, P0_EN, P1_EN,
        output P0_WADDR, P1_WADDR, P0_RADDR0, P0_RADDR1, P1_RADDR0, P1_RADDR1,
        input  BUNDLE_READY, ISSUE_VALID, ISSUE_PHASE, ISSUE_WADDR,
        input  WB_VALID, WB_WADDR, BUSY, STALL_COUNT, state_dbg
    );

    modport slave (
        input  FLUSH, BUNDLE_VALID, P0_EN, P1_EN,
        input  P0_WADDR, P1_WADDR, P0_RADDR0, P0_RADDR1, P1_RADDR0, P1_RADDR1,
        output BUNDLE_READY, ISSUE_VALID, ISSUE_PHASE, ISSUE_WADDR,
        output WB_VALID, WB_WADDR, BUSY, STALL_COUNT, state_dbg
    );
endinterface

// File: rtl/mtsp_mo_phase_scheduler.sv
// ---------------------------------------------------------------------------
// mtsp_mo_phase_scheduler
//   Sequences one unit-instruction bundle (phase #0 then phase #1) onto the
//   single shared MO datapath, at most one issue per cycle. Issue is held
//   while any source or destination GPR of the pending phase has a write in
//   flight (RAW/WAW). In-flight writes are tracked by a one-bit-per-GPR
//   scoreboard and a PIPE_LAT-deep writeback shift line.
//
// Ports:
//   CLK          clock
//   RST          synchronous, active-high reset
//   bus (slave)  FLUSH, bundle handshake + phase fields, issue strobe/phase/
//                dest, writeback strobe/dest, BUSY, STALL_COUNT, state_dbg
//
// Parameters:
//   GPR_AW    GPR address width (scoreboard is 2**GPR_AW bits)
//   PIPE_LAT  cycles from issue to writeback strobe (>= 1)
//
// Build option:
//   MTSP_SCHED_PERF_EN  when defined, STALL_COUNT counts hazard-stall cycles
//                       (saturating, cleared by RST only); otherwise it is 0.
// ---------------------------------------------------------------------------
module mtsp_mo_phase_scheduler #(
    parameter int GPR_AW   = 7,
    parameter int PIPE_LAT = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    mtsp_mo_phase_scheduler_if.slave   bus
);

    localparam int SB_N = 1 << GPR_AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PH0  = 2'd1,
        ST_PH1  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched bundle. P0_EN is carried by the state the FSM enters on accept.
    logic              lat_p1_en;
    logic [GPR_AW-1:0] lat_p0_waddr, lat_p0_raddr0, lat_p0_raddr1;
    logic [GPR_AW-1:0] lat_p1_waddr, lat_p1_raddr0, lat_p1_raddr1;

    logic [SB_N-1:0]   sb_q;                 // 1 = write to that GPR in flight
    logic [PIPE_LAT-1:0] sh_v;               // writeback shift line valids
    logic [GPR_AW-1:0] sh_a [PIPE_LAT];      // writeback shift line addresses
    logic [GPR_AW-1:0] last_issue_waddr_q;

    logic              hz0, hz1;
    logic              ready;
    logic              accept;
    logic              issue_fire;
    logic              issue_phase;
    logic [GPR_AW-1:0] issue_addr;

    // Hazards look only at the registered scoreboard: a clear that lands in
    // this cycle (WB_VALID high) still blocks issue until the next cycle.
    assign hz0 = sb_q[lat_p0_raddr0] | sb_q[lat_p0_raddr1] | sb_q[lat_p0_waddr];
    assign hz1 = sb_q[lat_p1_raddr0] | sb_q[lat_p1_raddr1] | sb_q[lat_p1_waddr];

    // -----------------------------------------------------------------------
    // Next state / issue / ready
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ready       = 1'b0;
        issue_fire  = 1'b0;
        issue_phase = 1'b0;
        issue_addr  = last_issue_waddr_q;

        case (state_q)
            ST_IDLE: begin
                ready = !bus.FLUSH;
            end
            ST_PH0: begin
                if (!bus.FLUSH && !hz0) begin
                    issue_fire = 1'b1;
                    issue_addr = lat_p0_waddr;
                    state_d    = lat_p1_en ? ST_PH1 : ST_IDLE;
                end
            end
            ST_PH1: begin
                // Final phase: the next bundle may be taken in the same cycle.
                if (!bus.FLUSH && !hz1) begin
                    issue_fire  = 1'b1;
                    issue_phase = 1'b1;
                    issue_addr  = lat_p1_waddr;
                    ready       = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Nothing is accepted or issued while reset is being applied.
        if (RST) begin
            ready       = 1'b0;
            issue_fire  = 1'b0;
            issue_phase = 1'b0;
        end

        accept = ready & bus.BUNDLE_VALID;
        if (accept) begin
            if (bus.P0_EN) begin
                state_d = ST_PH0;
            end else if (bus.P1_EN) begin
                state_d = ST_PH1;
            end else begin
                state_d = ST_IDLE;     // empty bundle consumed
            end
        end

        if (bus.FLUSH) begin
            state_d = ST_IDLE;
        end
    end

    // -----------------------------------------------------------------------
    // State and latched bundle
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q            <= ST_IDLE;
            lat_p1_en          <= 1'b0;
            lat_p0_waddr       <= '0;
            lat_p0_raddr0      <= '0;
            lat_p0_raddr1      <= '0;
            lat_p1_waddr       <= '0;
            lat_p1_raddr0      <= '0;
            lat_p1_raddr1      <= '0;
            last_issue_waddr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                lat_p1_en     <= bus.P1_EN;
                lat_p0_waddr  <= bus.P0_WADDR;
                lat_p0_raddr0 <= bus.P0_RADDR0;
                lat_p0_raddr1 <= bus.P0_RADDR1;
                lat_p1_waddr  <= bus.P1_WADDR;
                lat_p1_raddr0 <= bus.P1_RADDR0;
                lat_p1_raddr1 <= bus.P1_RADDR1;
            end else if (bus.FLUSH) begin
                lat_p1_en <= 1'b0;
            end
            if (issue_fire) begin
                last_issue_waddr_q <= issue_addr;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Writeback shift line. Address slots only move with a valid entry, so
    // the last slot holds the most recent writeback address between strobes.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            sh_v <= '0;
            for (int k = 0; k < PIPE_LAT; k++) begin
                sh_a[k] <= '0;
            end
        end else begin
            sh_v[0] <= issue_fire;
            if (issue_fire) begin
                sh_a[0] <= issue_addr;
            end
            for (int k = 1; k < PIPE_LAT; k++) begin
                sh_v[k] <= sh_v[k-1];
                if (sh_v[k-1]) begin
                    sh_a[k] <= sh_a[k-1];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Scoreboard. The bit clears at the end of the writeback-strobe cycle.
    // The set is written last so it wins if both hit the same GPR.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            sb_q <= '0;
        end else begin
            if (sh_v[PIPE_LAT-1]) begin
                sb_q[sh_a[PIPE_LAT-1]] <= 1'b0;
            end
            if (issue_fire) begin
                sb_q[issue_addr] <= 1'b1;
            end
        end
    end

`ifdef MTSP_SCHED_PERF_EN
    logic [15:0] stall_q;
    logic        stall_cyc;

    assign stall_cyc = !bus.FLUSH &&
                       (((state_q == ST_PH0) && hz0) || ((state_q == ST_PH1) && hz1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
        end else if (stall_cyc && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.STALL_COUNT = stall_q;
`else
    assign bus.STALL_COUNT = 16'h0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.BUNDLE_READY = ready;
    assign bus.ISSUE_VALID  = issue_fire;
    assign bus.ISSUE_PHASE  = issue_phase;
    assign bus.ISSUE_WADDR  = issue_addr;
    assign bus.WB_VALID     = sh_v[PIPE_LAT-1];
    assign bus.WB_WADDR     = sh_a[PIPE_LAT-1];
    assign bus.BUSY         = (state_q != ST_IDLE) | (|sb_q);
    assign bus.state_dbg    = state_q;

endmodule
